// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : AES-128 key-schedule constants, S-box table, word helpers, FSM enum.
// Rev    : 1.0
// ============================================================================
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// ============================================================================
// Module : aes_sub_word
// Brief  : Combinational 32-bit SubWord built from four S-box lookups.
// Rev    : 1.0
// ============================================================================
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign word_out[8*g +: 8] = SBOX[word_in[8*g +: 8]];
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module : aes_key_expansion
// Brief  : Iterative AES-128 key schedule, one round key per cycle, 11 keys
//          presented on a 1408-bit vector. AES_KEYEXP_RESTART_EN allows a new
//          key to restart expansion from DONE without a reset.
// Rev    : 1.0
// ============================================================================
module aes_key_expansion
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic          start,
  output logic [1407:0] out,
  output logic          finish
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [127:0]  r_rk [0:NR];
  logic [3:0]    r_cnt;
  logic          r_finish;
  logic          w_restart;
  logic          w_load;
  logic          w_step;
  logic [127:0]  w_prev;
  logic [127:0]  w_next_rk;
  logic [31:0]   w_sub;
  logic [31:0]   w_t;

`ifdef AES_KEYEXP_RESTART_EN
  logic [127:0]  r_key_lat;

  assign w_restart = (r_state == DONE) && start && (key != r_key_lat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_lat <= '0;
    end else if (w_load) begin
      r_key_lat <= key;
    end
  end
`else
  assign w_restart = 1'b0;
`endif

  // Load happens on the edge that leaves IDLE so rk0 is valid one cycle after start.
  assign w_load = ((r_state == IDLE) && start) || w_restart;
  assign w_step = (r_state == LOAD) || (r_state == BUSY);

  assign w_prev = r_rk[r_cnt - 4'd1];

  aes_sub_word u_sub_word (
    .word_in  (rot_word(w_prev[31:0])),
    .word_out (w_sub)
  );

  assign w_t = w_sub ^ {RCON[r_cnt], 24'h0};
  assign w_next_rk[127:96] = w_prev[127:96] ^ w_t;
  assign w_next_rk[95:64]  = w_prev[95:64]  ^ w_next_rk[127:96];
  assign w_next_rk[63:32]  = w_prev[63:32]  ^ w_next_rk[95:64];
  assign w_next_rk[31:0]   = w_prev[31:0]   ^ w_next_rk[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = BUSY;
      BUSY:    if (r_cnt == 4'(NR)) w_state_nxt = DONE;
      DONE:    if (w_restart) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      r_cnt    <= '0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= (w_state_nxt == DONE);
      if (w_load) begin
        r_rk[0] <= key;
        for (int i = 1; i <= NR; i++) r_rk[i] <= '0;
        r_cnt <= 4'd1;
      end else if (w_step) begin
        r_rk[r_cnt] <= w_next_rk;
        r_cnt       <= r_cnt + 4'd1;
      end
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_out
    assign out[1407-128*g -: 128] = r_rk[g];
  end

  assign finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_key_expansion
// Brief  : Self-checking bench; reference key schedule derived from GF(2^8).
// Rev    : 1.0
// ============================================================================
module tb_aes_key_expansion;

  logic          clk;
  logic          rst;
  logic [127:0]  key;
  logic          start;
  logic [1407:0] out;
  logic          finish;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .start  (start),
    .out    (out),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] get_rk(input logic [1407:0] v, input int i);
    return v[1407-128*i -: 128];
  endfunction

  logic [1407:0] m_full;
  logic [1407:0] m_out = '0;
  logic          m_fin = 1'b0;
  logic [127:0]  m_lat = '0;
  int            m_phase = 0;   // 0 idle, 1 expanding, 2 done
  int            m_k = 0;
  bit            chk_en = 1'b0;
  bit            m_restart;

  always @(posedge clk) begin
`ifdef AES_KEYEXP_RESTART_EN
    m_restart = (m_phase == 2) && start && (key != m_lat);
`else
    m_restart = 1'b0;
`endif
    if (rst) begin
      m_phase = 0; m_out = '0; m_fin = 1'b0;
    end else if ((m_phase == 0 && start) || m_restart) begin
      m_full = expand_key(key);
      m_lat  = key;
      m_out  = '0;
      m_out[1407:1280] = key;
      m_k = 0; m_phase = 1; m_fin = 1'b0;
    end else if (m_phase == 1) begin
      m_k++;
      m_out[1407-128*m_k -: 128] = m_full[1407-128*m_k -: 128];
      if (m_k == 10) begin m_phase = 2; m_fin = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (finish !== m_fin) begin
        bad++;
        $display("FAIL cyc_finish t=%0t got=%b want=%b", $time, finish, m_fin);
      end
      total++;
      if (out !== m_out) begin
        bad++;
        for (int i = 0; i < 11; i++) begin
          if (get_rk(out, i) !== get_rk(m_out, i)) begin
            $display("FAIL cyc_out t=%0t rk%0d got=%h want=%h", $time, i, get_rk(out, i), get_rk(m_out, i));
            break;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check128(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Pulses start with key k; optionally zeroes the key at cycle chg; returns cycles to finish.
  task automatic start_and_wait(input logic [127:0] k, input int chg, output int lat);
    @(negedge clk); key = k; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (finish !== 1'b1 && lat < 40) begin
      if (lat == chg) key = '0;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  logic [1407:0] snap;

  initial begin
    rst = 1'b1; start = 1'b0; key = '0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    check128("model_sbox", {sb[8'h00], sb[8'h53], sb[8'hff]}, {8'h63, 8'hed, 8'h16});
    m_full = expand_key(K1);
    check128("model_k1_rk1", get_rk(m_full, 1), K1_RK1);
    check128("model_k1_rk10", get_rk(m_full, 10), K1_RK10);

    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    check128("reset_rk0", get_rk(out, 0), '0);
    check_int("reset_finish", int'(finish), 0);
    rst = 1'b0;

    // FIPS vector, key zeroed mid-expansion
    start_and_wait(K1, 3, lat);
    check_int("k1_latency", lat, 11);
    check128("k1_rk0", get_rk(out, 0), K1);
    check128("k1_rk1", get_rk(out, 1), K1_RK1);
    check128("k1_rk10", get_rk(out, 10), K1_RK10);
    snap = out;
    repeat (20) @(negedge clk);
    check_int("hold_finish", int'(finish), 1);
    check128("hold_rk10", get_rk(out, 10), get_rk(snap, 10));

    // New key from DONE
    start_and_wait('0, 0, lat);
`ifdef AES_KEYEXP_RESTART_EN
    check_int("restart_latency", lat, 11);
    check128("restart_rk1", get_rk(out, 1), K0_RK1);
    check128("restart_rk10", get_rk(out, 10), K0_RK10);
`else
    repeat (12) @(negedge clk);
    check_int("sticky_finish", int'(finish), 1);
    check128("sticky_rk0", get_rk(out, 0), K1);
    check128("sticky_rk10", get_rk(out, 10), K1_RK10);
`endif

    // Zero key
    do_reset();
    start_and_wait('0, 0, lat);
    check_int("k0_latency", lat, 11);
    check128("k0_rk1", get_rk(out, 1), K0_RK1);
    check128("k0_rk10", get_rk(out, 10), K0_RK10);

    // Reset in the middle of BUSY
    do_reset();
    @(negedge clk); key = K1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check128("midrst_rk0", get_rk(out, 0), '0);
    check128("midrst_rk1", get_rk(out, 1), '0);
    check_int("midrst_finish", int'(finish), 0);
    start_and_wait(K1, 0, lat);
    check128("rerun_rk10", get_rk(out, 10), K1_RK10);

    // Randomized runs checked cycle-by-cycle against the model
    for (int it = 0; it < 20; it++) begin
      int hold;
      do_reset();
      @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (c == 2 && $urandom_range(0, 1) == 1) key = {$urandom, $urandom, $urandom, $urandom};
      end
      start = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
      repeat (14) @(negedge clk);
      if (m_phase == 2) check128("rand_rk10", get_rk(out, 10), get_rk(m_full, 10));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
